// File: rtl/mdio_pkg.sv
// Shared MDIO frame encodings, field widths and master FSM state type.
package mdio_pkg;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP_C22_WR   = 2'b01;
  localparam logic [1:0] OP_C22_RD   = 2'b10;
  localparam logic [1:0] OP_C45_ADDR = 2'b00;
  localparam logic [1:0] OP_C45_WR   = 2'b01;
  localparam logic [1:0] OP_C45_RD   = 2'b11;
  localparam logic [1:0] OP_C45_PRIA = 2'b10;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} mdio_state_e;
endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: toggles MDC every CLK_DIV system clocks while a frame runs,
// and flags the cycles in which MDC is about to rise or fall.
module mdio_clk_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_mdc,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc     = i_run && (cnt == CNT_LAST);
  assign o_rise = tc && !o_mdc;
  assign o_fall = tc && o_mdc;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      cnt   <= '0;
      o_mdc <= 1'b0;
    end else if (tc) begin
      cnt   <= '0;
      o_mdc <= ~o_mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mdio_master.sv
// MDIO management master: runs one Clause 22/45 frame per accepted command
// and returns read data plus a turnaround error flag.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32,
  parameter bit C45_EN       = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_c45,
  input  logic [1:0]         i_cmd_op,
  input  logic [PHYAD_W-1:0] i_cmd_phyad,
  input  logic [REGAD_W-1:0] i_cmd_regad,
  input  logic [DATA_W-1:0]  i_cmd_data,
  output logic               o_rsp_valid,
  output logic [DATA_W-1:0]  o_rsp_data,
  output logic               o_rsp_err,
  output logic               o_busy,
  output logic               o_mdc,
  output logic               o_mdo,
  output logic               o_mdo_t,
  input  logic               i_mdi
);
  localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

  mdio_state_e state, state_nxt;
  logic [5:0]  bit_cnt, bit_last;
  logic        run, rise, fall, bit_end;
  logic        accept, c45_reject, rd_q, err_q;
  logic [15:0] hdr_ld, hdr_sr, dat_sr, rx_sr;

  assign o_cmd_ready = (state == IDLE) && !i_rst;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign c45_reject  = i_cmd_c45 && !C45_EN;
  assign run         = state inside {PRE, HDR, TA, DATA};
  assign o_busy      = (state != IDLE);
  assign o_rsp_valid = (state == DONE);
  assign o_rsp_err   = err_q;
  assign bit_end     = fall && (bit_cnt == bit_last);

  // Header plus the TA pair we drive: 10 for writes, released (11) for reads.
  assign hdr_ld = {i_cmd_c45 ? ST_C45 : ST_C22, i_cmd_op, i_cmd_phyad, i_cmd_regad,
                   i_cmd_op[1] ? 2'b11 : 2'b10};

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_run (run),
    .o_mdc (o_mdc),
    .o_rise(rise),
    .o_fall(fall)
  );

  always_comb begin
    bit_last = 6'd0;
    case (state)
      PRE:     bit_last = PRE_LAST;
      HDR:     bit_last = 6'd13;
      TA:      bit_last = 6'd1;
      DATA:    bit_last = 6'd15;
      default: bit_last = 6'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (c45_reject)             state_nxt = DONE;
        else if (PREAMBLE_LEN == 0) state_nxt = HDR;
        else                        state_nxt = PRE;
      end
      PRE:     if (bit_end) state_nxt = HDR;
      HDR:     if (bit_end) state_nxt = TA;
      TA:      if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (state_nxt != state)) bit_cnt <= '0;
    else if (fall)                     bit_cnt <= bit_cnt + 6'd1;
  end

  // Pad outputs and response; bus pins only move at frame start or MDC fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mdo      <= 1'b1;
      o_mdo_t    <= 1'b0;
      o_rsp_data <= '0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else if (accept) begin
      rd_q    <= i_cmd_op[1];
      err_q   <= c45_reject;
      o_mdo_t <= !c45_reject;
      o_mdo   <= (PREAMBLE_LEN == 0) ? hdr_ld[15] : 1'b1;
      if (c45_reject) o_rsp_data <= '0;
    end else if (state == PRE) begin
      if (bit_end) o_mdo <= hdr_sr[15];
    end else if (state inside {HDR, TA, DATA}) begin
      if (state == DATA && bit_end) begin
        o_mdo      <= 1'b1;
        o_mdo_t    <= 1'b0;
        o_rsp_data <= rd_q ? rx_sr : '0;
      end else if (fall) begin
        o_mdo <= hdr_sr[14];
        if (state == HDR && bit_end && rd_q) o_mdo_t <= 1'b0;
      end
      if (rise && state == TA && bit_cnt == 6'd1 && rd_q && i_mdi) err_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      hdr_sr <= hdr_ld;
      dat_sr <= i_cmd_op[1] ? '1 : i_cmd_data;
    end else if (fall && (state inside {HDR, TA, DATA})) begin
      {hdr_sr, dat_sr} <= {hdr_sr[14:0], dat_sr, 1'b1};
    end
    if (rise && state == DATA) rx_sr <= {rx_sr[14:0], i_mdi};
  end
endmodule
